// File: rtl/vproc_result_arb_pkg.sv
// Shared types and constants for the vector-unit result arbiter.
package vproc_result_arb_pkg;

   typedef enum logic {
      RESULT_ARB_FIXED = 1'b0,
      RESULT_ARB_RR    = 1'b1
   } vproc_result_arb_mode_e;

   localparam int unsigned VPROC_RESULT_EXCCODE_W = 6;
   localparam int unsigned VPROC_RESULT_RD_W      = 5;
   localparam int unsigned VPROC_RESULT_DATA_W    = 32;

   // Index width that stays legal (>=1 bit) for single-entry structures.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vproc_result_arb_if.sv
// Source-side and XIF-result-side bundle of the result arbiter.
interface vproc_result_arb_if
   import vproc_result_arb_pkg::*;
#(
   parameter int unsigned N_SRC    = 4,
   parameter int unsigned XIF_ID_W = 3
);
   logic [N_SRC-1:0]                          src_valid_i;
   logic [N_SRC-1:0]                          src_ready_o;
   logic [N_SRC*XIF_ID_W-1:0]                 src_id_i;
   logic [N_SRC-1:0]                          src_we_i;
   logic [N_SRC*VPROC_RESULT_RD_W-1:0]        src_rd_i;
   logic [N_SRC*VPROC_RESULT_DATA_W-1:0]      src_data_i;
   logic [N_SRC-1:0]                          src_exc_i;
   logic [N_SRC*VPROC_RESULT_EXCCODE_W-1:0]   src_exccode_i;

   logic                                      result_valid_o;
   logic                                      result_ready_i;
   logic [XIF_ID_W-1:0]                       result_id_o;
   logic                                      result_we_o;
   logic [VPROC_RESULT_RD_W-1:0]              result_rd_o;
   logic [VPROC_RESULT_DATA_W-1:0]            result_data_o;
   logic                                      result_exc_o;
   logic [VPROC_RESULT_EXCCODE_W-1:0]         result_exccode_o;
   logic [N_SRC-1:0]                          grant_o;

   // Producers and the XIF consumer.
   modport master (
      output src_valid_i, src_id_i, src_we_i, src_rd_i, src_data_i, src_exc_i, src_exccode_i,
      output result_ready_i,
      input  src_ready_o,
      input  result_valid_o, result_id_o, result_we_o, result_rd_o, result_data_o,
      input  result_exc_o, result_exccode_o, grant_o
   );

   // The arbiter.
   modport slave (
      input  src_valid_i, src_id_i, src_we_i, src_rd_i, src_data_i, src_exc_i, src_exccode_i,
      input  result_ready_i,
      output src_ready_o,
      output result_valid_o, result_id_o, result_we_o, result_rd_o, result_data_o,
      output result_exc_o, result_exccode_o, grant_o
   );
endinterface

// File: rtl/vproc_result_fifo.sv
// Per-source result FIFO; head is visible combinationally, storage is not reset.
module vproc_result_fifo
   import vproc_result_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             async_rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned PTR_W = idx_w(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Overflow pushes and underflow pops are dropped here as a second line of defence.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/vproc_result_arb.sv
// Arbitrates N_SRC vector-unit result producers onto the single XIF result channel,
// with per-source FIFOs, optional empty-FIFO bypass and fixed/round-robin selection.
module vproc_result_arb
   import vproc_result_arb_pkg::*;
#(
   parameter int unsigned            N_SRC          = 4,
   parameter int unsigned            DEPTH          = 2,
   parameter int unsigned            XIF_ID_W       = 3,
   parameter logic [N_SRC-1:0]       BYPASS_MASK    = N_SRC'(4'b0011),
   parameter vproc_result_arb_mode_e ARB_MODE       = RESULT_ARB_FIXED,
   parameter bit                     DONT_CARE_ZERO = 1'b0
) (
   input logic               clk_i,
   input logic               async_rst_ni,
   vproc_result_arb_if.slave bus
);
   localparam int unsigned EXC_W    = VPROC_RESULT_EXCCODE_W;
   localparam int unsigned RD_W     = VPROC_RESULT_RD_W;
   localparam int unsigned DATA_W   = VPROC_RESULT_DATA_W;
   localparam int unsigned OFS_EXC  = EXC_W;
   localparam int unsigned OFS_DATA = OFS_EXC + 1;
   localparam int unsigned OFS_RD   = OFS_DATA + DATA_W;
   localparam int unsigned OFS_WE   = OFS_RD + RD_W;
   localparam int unsigned OFS_ID   = OFS_WE + 1;
   localparam int unsigned PL_W     = OFS_ID + XIF_ID_W;
   localparam int unsigned IDX_W    = idx_w(N_SRC);
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

   logic [N_SRC-1:0][PL_W-1:0]  src_pl, head, cand_pl;
   logic [N_SRC-1:0][CNT_W-1:0] count;
   logic [N_SRC-1:0]            full, empty, cand, push, pop, src_ready;
   logic [IDX_W-1:0]            win_idx;
   logic [IDX_W-1:0]            lock_idx_q, lock_idx_d;
   logic [IDX_W-1:0]            rr_q, rr_d;
   logic                        lock_q, lock_d;
   logic                        win_found, hs;
   logic [PL_W-1:0]             win_pl;

   assign hs = win_found & bus.result_ready_i;

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      logic is_win;

      assign src_pl[i] = {bus.src_id_i[i*XIF_ID_W +: XIF_ID_W],
                          bus.src_we_i[i],
                          bus.src_rd_i[i*RD_W +: RD_W],
                          bus.src_data_i[i*DATA_W +: DATA_W],
                          bus.src_exc_i[i],
                          bus.src_exccode_i[i*EXC_W +: EXC_W]};

      // Ready depends only on the registered count, never on result_ready_i.
      assign src_ready[i] = (count[i] != CNT_W'(DEPTH));
      assign is_win       = win_found & (win_idx == IDX_W'(i));

      assign cand[i]    = ~empty[i] | (BYPASS_MASK[i] & bus.src_valid_i[i]);
      assign cand_pl[i] = empty[i] ? src_pl[i] : head[i];

      assign pop[i]  = hs & is_win & ~empty[i];
      // A bypass winner that handshakes this cycle never touches its FIFO.
      assign push[i] = bus.src_valid_i[i] & src_ready[i] & ~(hs & is_win & empty[i]);

      vproc_result_fifo #(
         .WIDTH (PL_W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk_i        (clk_i),
         .async_rst_ni (async_rst_ni),
         .push_i       (push[i]),
         .pop_i        (pop[i]),
         .data_i       (src_pl[i]),
         .head_o       (head[i]),
         .count_o      (count[i]),
         .full_o       (full[i]),
         .empty_o      (empty[i])
      );
   end

   assign bus.src_ready_o = src_ready;

   // A stalled winner stays locked; stalled bypass entries are in their FIFO head by now.
   always_comb begin
      logic [IDX_W-1:0] sel;
      int unsigned      s;
      win_idx   = '0;
      win_found = 1'b0;
      sel       = '0;
      s         = 0;
      if (lock_q) begin
         win_idx   = lock_idx_q;
         win_found = cand[lock_idx_q];
      end else begin
         for (int unsigned k = 0; k < N_SRC; k++) begin
            s = k;
            if (ARB_MODE == RESULT_ARB_RR) begin
               s = s + 32'(rr_q);
               if (s >= N_SRC) s = s - N_SRC;
            end
            sel = IDX_W'(s);
            if (!win_found && cand[sel]) begin
               win_found = 1'b1;
               win_idx   = sel;
            end
         end
      end
   end

   assign win_pl = cand_pl[win_idx];

   always_comb begin
      bus.result_valid_o = win_found;
      bus.grant_o        = win_found ? (N_SRC'(1) << win_idx) : '0;
      bus.result_exc_o   = win_found & win_pl[OFS_EXC];
      bus.result_we_o    = win_found & win_pl[OFS_WE] & ~win_pl[OFS_EXC];
      if (win_found) begin
         bus.result_id_o      = win_pl[OFS_ID +: XIF_ID_W];
         bus.result_rd_o      = win_pl[OFS_RD +: RD_W];
         bus.result_data_o    = win_pl[OFS_DATA +: DATA_W];
         bus.result_exccode_o = win_pl[0 +: EXC_W];
      end else if (DONT_CARE_ZERO) begin
         bus.result_id_o      = '0;
         bus.result_rd_o      = '0;
         bus.result_data_o    = '0;
         bus.result_exccode_o = '0;
      end else begin
         bus.result_id_o      = 'x;
         bus.result_rd_o      = 'x;
         bus.result_data_o    = 'x;
         bus.result_exccode_o = 'x;
      end
   end

   always_comb begin
      lock_d     = win_found & ~bus.result_ready_i;
      lock_idx_d = win_idx;
      rr_d       = rr_q;
      if (hs) begin
         rr_d = (win_idx == IDX_W'(N_SRC - 1)) ? '0 : win_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         rr_q       <= '0;
      end else begin
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         rr_q       <= rr_d;
      end
   end

   a_grant_onehot: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
      $onehot0(bus.grant_o) && (bus.result_valid_o == (bus.grant_o != '0)));

   a_ready_is_not_full: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
      bus.src_ready_o == ~full);

   a_hold_stalled: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
      (bus.result_valid_o && !bus.result_ready_i) |=>
         (bus.result_valid_o && $stable(bus.grant_o) && $stable(bus.result_id_o) &&
          $stable(bus.result_data_o) && $stable(bus.result_exc_o)));

endmodule
